// File: rtl/uart_pkg.sv
// Shared encodings for the uart receive path: config fields, status bits,
// receiver states and the FIFO entry width.
package uart_pkg;

  localparam logic [1:0] DB5 = 2'b00;
  localparam logic [1:0] DB6 = 2'b01;
  localparam logic [1:0] DB7 = 2'b10;
  localparam logic [1:0] DB8 = 2'b11;

  localparam int PAR_EN  = 1;
  localparam int PAR_ODD = 0;

  localparam int ST_PE  = 0;
  localparam int ST_FE  = 1;
  localparam int ST_BRK = 2;

  localparam int ENTRY_W = 11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    BRKWAIT = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// A write while full is accepted only if a pop frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [AW:0]      o_level,
  output logic             o_drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_s, do_pop_s, do_push_s;

  assign full_s    = (count_q == (AW+1)'(DEPTH));
  assign o_empty   = (count_q == '0);
  assign do_pop_s  = i_pop && !o_empty;
  assign do_push_s = i_push && (!full_s || do_pop_s);
  assign o_drop    = i_push && full_s && !do_pop_s;
  assign o_level   = count_q;
  // Head word is forced to zero when empty so the output is defined from reset.
  assign o_rdata   = o_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (5-8 data bits, optional parity, break detect)
// feeding a status-tagged FIFO with threshold/idle-timeout interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVS        = 16,
  parameter int TOUT_BITS  = 32,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [15:0]   i_div,
  input  logic [1:0]    i_dbits,
  input  logic [1:0]    i_parity,
  input  logic [LW-1:0] i_thresh,
  input  logic          i_uart_rxd,
  output logic          o_rx_valid,
  input  logic          i_rx_ready,
  output logic [7:0]    o_rx_data,
  output logic [2:0]    o_rx_stat,
  output logic [LW-1:0] o_level,
  output logic          o_overrun,
  input  logic          i_clr_overrun,
  output logic          o_timeout,
  output logic          o_rx_int
);

  localparam int SW = $clog2(OVS);
  localparam int TW = $clog2(TOUT_BITS + 1);

  logic sync1_q, sync2_q, prev_q;
  rx_state_e state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] samp_q, samp_d;
  logic s0_q, s0_d, s1_q, s1_d, par_q, par_d;
  logic [3:0] bit_cnt_q, bit_cnt_d, nbits_s;
  logic [7:0] data_q, data_d;
  logic fall_s, tick_s, mid_tick_s, end_tick_s, maj_s;
  logic pe_s, fe_s, brk_s, push_s, pop_s, empty_s, drop_s;
  logic [ENTRY_W-1:0] entry_s, head_s;
  logic [LW-1:0] level_s;
  logic [15:0] idle_div_q, idle_div_d;
  logic [SW-1:0] idle_samp_q, idle_samp_d;
  logic [TW-1:0] tout_cnt_q, tout_cnt_d;
  logic timeout_q, timeout_d, overrun_q, overrun_d, tout_run_s, bit_tick_s;

  assign fall_s     = prev_q && !sync2_q;
  assign tick_s     = (state_q != IDLE) && (tick_cnt_q == i_div);
  assign mid_tick_s = tick_s && (samp_q == SW'(OVS/2 + 1));
  assign end_tick_s = tick_s && (samp_q == SW'(OVS - 1));
  assign maj_s      = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign nbits_s    = 4'd5 + {2'b00, i_dbits};

  assign pe_s   = i_parity[PAR_EN] && ((^data_q ^ par_q) != i_parity[PAR_ODD]);
  assign fe_s   = !maj_s;
  assign brk_s  = fe_s && (data_q == 8'd0) && (!i_parity[PAR_EN] || !par_q);
  assign push_s = (state_q == STOP) && mid_tick_s;
  assign pop_s  = !empty_s && i_rx_ready;

  // Assemble the FIFO entry from the finished frame.
  always_comb begin
    entry_s              = '0;
    entry_s[7:0]         = data_q;
    entry_s[8 + ST_PE]   = pe_s;
    entry_s[8 + ST_FE]   = fe_s;
    entry_s[8 + ST_BRK]  = brk_s;
  end

  // Bit timebase and receive FSM next state.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    samp_d     = samp_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_d      = par_q;

    if (state_q == IDLE) begin
      tick_cnt_d = 16'd0;
      samp_d     = '0;
    end else if (tick_s) begin
      tick_cnt_d = 16'd0;
      samp_d     = (samp_q == SW'(OVS - 1)) ? '0 : samp_q + SW'(1);
    end else begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end

    if (tick_s && (samp_q == SW'(OVS/2 - 1))) s0_d = sync2_q;
    else s0_d = s0_q;
    if (tick_s && (samp_q == SW'(OVS/2))) s1_d = sync2_q;
    else s1_d = s1_q;

    case (state_q)
      IDLE: begin
        if (fall_s) begin
          state_d   = START;
          data_d    = 8'd0;
          bit_cnt_d = 4'd0;
          par_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (mid_tick_s && maj_s) state_d = IDLE;
        else if (end_tick_s)     state_d = DATA;
        else                     state_d = START;
      end
      DATA: begin
        if (mid_tick_s) begin
          if (!bit_cnt_q[3]) data_d[bit_cnt_q[2:0]] = maj_s;
          else               data_d = data_q;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (end_tick_s && (bit_cnt_q >= nbits_s)) begin
          state_d = i_parity[PAR_EN] ? PARITY : STOP;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (mid_tick_s)      par_d   = maj_s;
        else if (end_tick_s) state_d = STOP;
        else                 state_d = PARITY;
      end
      // Leave at the stop sample point so a back-to-back start edge is not missed.
      STOP: begin
        if (mid_tick_s) state_d = brk_s ? BRKWAIT : IDLE;
        else            state_d = STOP;
      end
      BRKWAIT: begin
        if (sync2_q) state_d = IDLE;
        else         state_d = BRKWAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle bit-time counter driving the timeout flag, plus overrun flag.
  always_comb begin
    idle_div_d  = idle_div_q;
    idle_samp_d = idle_samp_q;
    tout_cnt_d  = tout_cnt_q;
    if (pop_s || push_s || !tout_run_s) begin
      idle_div_d  = 16'd0;
      idle_samp_d = '0;
      tout_cnt_d  = '0;
    end else if (bit_tick_s) begin
      idle_div_d  = 16'd0;
      idle_samp_d = '0;
      tout_cnt_d  = (tout_cnt_q == TW'(TOUT_BITS)) ? tout_cnt_q : tout_cnt_q + TW'(1);
    end else if (idle_div_q == i_div) begin
      idle_div_d  = 16'd0;
      idle_samp_d = idle_samp_q + SW'(1);
    end else begin
      idle_div_d = idle_div_q + 16'd1;
    end

    if (pop_s || (level_s == '0))          timeout_d = 1'b0;
    else if (tout_cnt_q == TW'(TOUT_BITS)) timeout_d = 1'b1;
    else                                   timeout_d = timeout_q;

    if (i_clr_overrun) overrun_d = 1'b0;
    else if (drop_s)   overrun_d = 1'b1;
    else               overrun_d = overrun_q;
  end

  assign tout_run_s = (state_q == IDLE) && (level_s != '0);
  assign bit_tick_s = (idle_div_q == i_div) && (idle_samp_q == SW'(OVS - 1));

  // State registers; the synchroniser resets high so reset never looks like a start.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      tick_cnt_q  <= 16'd0;
      samp_q      <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      bit_cnt_q   <= 4'd0;
      data_q      <= 8'd0;
      par_q       <= 1'b0;
      idle_div_q  <= 16'd0;
      idle_samp_q <= '0;
      tout_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= i_uart_rxd;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_q      <= samp_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      par_q       <= par_d;
      idle_div_q  <= idle_div_d;
      idle_samp_q <= idle_samp_d;
      tout_cnt_q  <= tout_cnt_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push_s),
    .i_wdata   (entry_s),
    .i_pop     (pop_s),
    .o_rdata   (head_s),
    .o_empty   (empty_s),
    .o_level   (level_s),
    .o_drop    (drop_s)
  );

  assign o_rx_valid = !empty_s;
  assign o_rx_data  = head_s[7:0];
  assign o_rx_stat  = head_s[10:8];
  assign o_level    = level_s;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;
  assign o_rx_int   = ((i_thresh != '0) && (level_s >= i_thresh)) || timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a frame-level reference
// model (expected FIFO contents kept as a queue of {brk,fe,pe,data}).
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int BITC  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   div;
  logic [1:0]    dbits, par;
  logic [LW-1:0] thresh;
  logic          rxd, ready, clr;
  logic          valid, ovr, tmo, irq;
  logic [7:0]    rdata;
  logic [2:0]    stat;
  logic [LW-1:0] level;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .OVS(16), .TOUT_BITS(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_div(div), .i_dbits(dbits), .i_parity(par),
    .i_thresh(thresh), .i_uart_rxd(rxd), .o_rx_valid(valid), .i_rx_ready(ready),
    .o_rx_data(rdata), .o_rx_stat(stat), .o_level(level), .o_overrun(ovr),
    .i_clr_overrun(clr), .o_timeout(tmo), .o_rx_int(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic par_bit(input logic [7:0] d, input bit pbad);
    int nb;
    logic [7:0] m;
    nb = 5 + int'(dbits);
    m  = d & (8'hFF >> (8 - nb));
    return (^m) ^ par[0] ^ pbad;
  endfunction

  // Expected entry from the frame as sent: status in {brk,fe,pe}, data masked to length.
  function automatic logic [10:0] model(input logic [7:0] d, input bit pbad, input bit stop);
    int nb;
    logic [7:0] m;
    logic pe, fe, brk;
    nb  = 5 + int'(dbits);
    m   = d & (8'hFF >> (8 - nb));
    pe  = par[1] && pbad;
    fe  = !stop;
    brk = fe && (m == 8'd0) && (!par[1] || !par_bit(d, pbad));
    return {brk, fe, pe, m};
  endfunction

  task automatic send(input logic [7:0] d, input bit pbad, input bit stop, input int pop_at);
    bit bits[$];
    int nb;
    logic [10:0] e;
    nb = 5 + int'(dbits);
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    if (par[1]) bits.push_back(par_bit(d, pbad));
    bits.push_back(stop);
    for (int c = 0; c < bits.size() * BITC; c++) begin
      @(negedge clk);
      rxd   = bits[c / BITC];
      ready = (c == pop_at);
      if (c == pop_at && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("coincident_pop_head", rdata, e[7:0]);
      end
    end
    @(negedge clk);
    rxd   = 1'b1;
    ready = 1'b0;
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BITC) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    int w;
    logic [10:0] e;
    w = 0;
    @(negedge clk);
    while (!valid && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!valid) begin
      chk({tag, "_valid_timeout"}, 32'(valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_word"}, 32'(valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 32'(rdata), 32'(e[7:0]));
      chk({tag, "_stat"}, 32'(stat), 32'(e[10:8]));
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit pbad, stop;
    int w;

    rst_n = 1'b0; div = 16'd3; dbits = 2'b11; par = 2'b00; thresh = '0;
    rxd = 1'b1; ready = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(rdata), 32'd0);
    chk("rst_stat", 32'(stat), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overrun", 32'(ovr), 32'd0);
    chk("rst_timeout", 32'(tmo), 32'd0);
    chk("rst_int", 32'(irq), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // 8N1 pair, no pops until both are in
    exp_q.push_back(model(8'h55, 1'b0, 1'b1)); send(8'h55, 1'b0, 1'b1, -1); idle(2);
    exp_q.push_back(model(8'hA3, 1'b0, 1'b1)); send(8'hA3, 1'b0, 1'b1, -1); idle(2);
    chk("t1_level", 32'(level), 32'd2);
    pop_check("t1_a");
    pop_check("t1_b");

    // 7E1 with wrong parity, then 5O1 with correct parity
    dbits = 2'b10; par = 2'b10;
    exp_q.push_back(model(8'h41, 1'b1, 1'b1)); send(8'h41, 1'b1, 1'b1, -1); idle(2);
    pop_check("t2_7e1");
    dbits = 2'b00; par = 2'b11;
    exp_q.push_back(model(8'h1F, 1'b0, 1'b1)); send(8'h1F, 1'b0, 1'b1, -1); idle(2);
    pop_check("t2_5o1");

    // Break: line low for 20 bit-times
    dbits = 2'b11; par = 2'b00;
    exp_q.push_back(model(8'h00, 1'b0, 1'b0));
    @(negedge clk); rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(2);
    chk("t3_level", 32'(level), 32'd1);
    pop_check("t3_break");
    exp_q.push_back(model(8'h12, 1'b0, 1'b1)); send(8'h12, 1'b0, 1'b1, -1); idle(2);
    pop_check("t3_after");

    // 24-clock glitch must be rejected as a false start
    @(negedge clk); rxd = 1'b0;
    repeat (24) @(negedge clk);
    rxd = 1'b1;
    idle(2);
    chk("t4_no_entry", 32'(level), 32'd0);
    exp_q.push_back(model(8'h7E, 1'b0, 1'b1)); send(8'h7E, 1'b0, 1'b1, -1); idle(2);
    pop_check("t4_after");

    // Overrun: five bytes into a four-deep FIFO
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h30 + i);
      if (i < DEPTH) exp_q.push_back(model(d, 1'b0, 1'b1));
      send(d, 1'b0, 1'b1, -1);
      idle(1);
    end
    chk("t5_level_full", 32'(level), 32'd4);
    chk("t5_overrun_set", 32'(ovr), 32'd1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("t5_overrun_clr", 32'(ovr), 32'd0);
    // Pop lands in the write cycle of the sixth byte's stop sample
    exp_q.push_back(model(8'h66, 1'b0, 1'b1));
    send(8'h66, 1'b0, 1'b1, 618);
    idle(1);
    chk("t5_level_after_coinc", 32'(level), 32'd4);
    chk("t5_no_overrun_coinc", 32'(ovr), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("t5_drain");

    // Threshold and idle timeout
    thresh = LW'(3);
    exp_q.push_back(model(8'hC1, 1'b0, 1'b1)); send(8'hC1, 1'b0, 1'b1, -1); idle(1);
    exp_q.push_back(model(8'hC2, 1'b0, 1'b1)); send(8'hC2, 1'b0, 1'b1, -1);
    chk("t6_int_below_thresh", 32'(irq), 32'd0);
    chk("t6_level2", 32'(level), 32'd2);
    idle(29);
    chk("t6_timeout_early", 32'(tmo), 32'd0);
    w = 0;
    while (!tmo && w < 6 * BITC) begin
      @(negedge clk);
      w++;
    end
    chk("t6_timeout_set", 32'(tmo), 32'd1);
    chk("t6_int_timeout", 32'(irq), 32'd1);
    pop_check("t6_pop");
    chk("t6_timeout_clr", 32'(tmo), 32'd0);
    exp_q.push_back(model(8'hC3, 1'b0, 1'b1)); send(8'hC3, 1'b0, 1'b1, -1); idle(1);
    chk("t6_int_level2", 32'(irq), 32'd0);
    exp_q.push_back(model(8'hC4, 1'b0, 1'b1)); send(8'hC4, 1'b0, 1'b1, -1);
    chk("t6_level3", 32'(level), 32'd3);
    chk("t6_int_thresh", 32'(irq), 32'd1);
    thresh = '0;
    for (int i = 0; i < 3; i++) pop_check("t6_drain");

    // Random frames across all lengths, parity modes, errors and breaks
    for (int i = 0; i < 16; i++) begin
      dbits = 2'($urandom_range(0, 3));
      par   = 2'($urandom_range(0, 3));
      d     = 8'($urandom);
      if ($urandom_range(0, 4) == 0) d = 8'd0;
      pbad  = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 4) != 0);
      exp_q.push_back(model(d, pbad, stop));
      send(d, pbad, stop, -1);
      idle(2);
      pop_check("rnd");
    end

    // Reset mid-frame aborts the frame and empties the FIFO
    dbits = 2'b11; par = 2'b00;
    send(8'h99, 1'b0, 1'b1, -1); idle(1);
    @(negedge clk); rxd = 1'b0;
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    rxd = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    exp_q.delete();
    exp_q.push_back(model(8'h3C, 1'b0, 1'b1)); send(8'h3C, 1'b0, 1'b1, -1); idle(2);
    pop_check("midrst_after");
    chk("final_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
